// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready handshake,
// and loads the IF/ID register with redirect, flush, stall and interrupt handling.
module if_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] ISR_VECTOR   = 32'h0000_0080,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Branch_s,
    input  logic [31:0] PC_in,
    input  logic        IE,
    input  logic        intr,
    input  logic        rfe,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] IFID_IR,
    output logic [31:0] PC_out,
    output logic        ISR,
    output logic [31:0] EPC
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        take_intr;

    assign pc_plus4        = pc + 32'd4;
    assign redirect        = Branch_s || rfe;
    assign redirect_target = Branch_s ? PC_in : EPC;
    assign take_intr       = IE && intr && !ISR && (state == FETCH) && !Stall;

    // The request is live in every state once reset is released.
    assign imem_req  = !rst;
    // PC is never moved while a request is outstanding, so it doubles as the held address.
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_VECTOR;
            pending <= 32'd0;
            IFID_IR <= NOP_WORD;
            PC_out  <= 32'd0;
            ISR     <= 1'b0;
            EPC     <= 32'd0;
        end else if (redirect) begin
            IFID_IR <= NOP_WORD;
            if (!Branch_s) begin
                ISR <= 1'b0;
            end
            if (state == FETCH || imem_ready) begin
                pc    <= redirect_target;
                state <= FETCH;
            end else begin
                pending <= redirect_target;
                state   <= DISCARD;
            end
        end else if (state == DISCARD) begin
            // Returning data belongs to the abandoned path; drop it and jump.
            IFID_IR <= NOP_WORD;
            if (imem_ready) begin
                pc    <= pending;
                state <= FETCH;
            end
        end else if (Flush) begin
            IFID_IR <= NOP_WORD;
            if (imem_ready) begin
                pc    <= pc_plus4;
                state <= FETCH;
            end else begin
                state <= WAIT;
            end
        end else if (take_intr) begin
            EPC     <= pc;
            pc      <= ISR_VECTOR;
            ISR     <= 1'b1;
            IFID_IR <= NOP_WORD;
            state   <= FETCH;
        end else if (Stall) begin
            state <= imem_ready ? FETCH : WAIT;
        end else if (imem_ready) begin
            IFID_IR <= imem_rdata;
            PC_out  <= pc_plus4;
            pc      <= pc_plus4;
            state   <= FETCH;
        end else begin
            IFID_IR <= NOP_WORD;
            state   <= WAIT;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; memory returns word = addr ^ 32'hC000_0000.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall, Flush, Branch_s, IE, intr, rfe, imem_ready;
    logic [31:0] PC_in;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr, IFID_IR, PC_out, EPC;
    logic        ISR;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hC000_0000;

    if_fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .Stall     (Stall),
        .Flush     (Flush),
        .Branch_s  (Branch_s),
        .PC_in     (PC_in),
        .IE        (IE),
        .intr      (intr),
        .rfe       (rfe),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .IFID_IR   (IFID_IR),
        .PC_out    (PC_out),
        .ISR       (ISR),
        .EPC       (EPC)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; Stall = 0; Flush = 0; Branch_s = 0; PC_in = 0;
        IE = 0; intr = 0; rfe = 0; imem_ready = 1'b1;
        step(); step();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_ir", IFID_IR, 32'h0);
        check("rst_pcout", PC_out, 32'h0);
        check("rst_isr", {31'd0, ISR}, 32'd0);
        check("rst_epc", EPC, 32'h0);
        rst = 1'b0;
        #1;
        check("req_after_rst", {31'd0, imem_req}, 32'd1);

        // zero-wait streaming
        step();
        check("s0_addr", imem_addr, 32'h4);
        check("s0_ir", IFID_IR, 32'hC000_0000);
        check("s0_pcout", PC_out, 32'h4);
        step();
        check("s1_addr", imem_addr, 32'h8);
        check("s1_ir", IFID_IR, 32'hC000_0004);
        check("s1_pcout", PC_out, 32'h8);

        // three wait cycles at 8
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_addr", imem_addr, 32'h8);
            check("wait_ir", IFID_IR, 32'h0);
        end
        imem_ready = 1'b1;
        step();
        check("wait_done_ir", IFID_IR, 32'hC000_0008);
        check("wait_done_pcout", PC_out, 32'hC);
        step();
        check("pre_stall_addr", imem_addr, 32'h10);

        // stall two cycles at 0x10
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_addr", imem_addr, 32'h10);
            check("stall_ir", IFID_IR, 32'hC000_000C);
            check("stall_pcout", PC_out, 32'h10);
        end
        Stall = 1'b0;
        step();
        check("unstall_ir", IFID_IR, 32'hC000_0010);
        check("unstall_pcout", PC_out, 32'h14);

        // branch during WAIT at 0x20
        for (int i = 0; i < 3; i++) step();
        check("to20_addr", imem_addr, 32'h20);
        imem_ready = 1'b0;
        step();
        check("w20_addr", imem_addr, 32'h20);
        Branch_s = 1'b1; PC_in = 32'h100;
        step();
        Branch_s = 1'b0;
        check("disc_addr", imem_addr, 32'h20);
        check("disc_ir", IFID_IR, 32'h0);
        step();
        check("disc2_addr", imem_addr, 32'h20);
        imem_ready = 1'b1;
        step();
        check("disc_done_addr", imem_addr, 32'h100);
        check("disc_drop_ir", IFID_IR, 32'h0);
        step();
        check("b100_ir", IFID_IR, 32'hC000_0100);
        check("b100_pcout", PC_out, 32'h104);

        // branch in FETCH to 0x40: single bubble
        Branch_s = 1'b1; PC_in = 32'h40;
        step();
        Branch_s = 1'b0;
        check("bf_addr", imem_addr, 32'h40);
        check("bf_ir", IFID_IR, 32'h0);

        // interrupt at 0x40
        IE = 1'b1; intr = 1'b1;
        step();
        check("int_epc", EPC, 32'h40);
        check("int_isr", {31'd0, ISR}, 32'd1);
        check("int_addr", imem_addr, 32'h80);
        check("int_ir", IFID_IR, 32'h0);
        step();
        check("noreent_addr", imem_addr, 32'h84);
        check("noreent_ir", IFID_IR, 32'hC000_0080);
        check("noreent_epc", EPC, 32'h40);
        intr = 1'b0; rfe = 1'b1;
        step();
        rfe = 1'b0;
        check("rfe_addr", imem_addr, 32'h40);
        check("rfe_isr", {31'd0, ISR}, 32'd0);
        check("rfe_ir", IFID_IR, 32'h0);

        // wrap at top of address space
        Branch_s = 1'b1; PC_in = 32'hFFFF_FFFC;
        step();
        Branch_s = 1'b0;
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_ir", IFID_IR, 32'h3FFF_FFFC);
        check("wrap_pcout", PC_out, 32'h0);

        // Branch_s and rfe together while in service
        intr = 1'b1;
        step();
        intr = 1'b0;
        check("int2_isr", {31'd0, ISR}, 32'd1);
        check("int2_epc", EPC, 32'h0);
        Branch_s = 1'b1; rfe = 1'b1; PC_in = 32'h200;
        step();
        Branch_s = 1'b0; rfe = 1'b0;
        check("br_rfe_addr", imem_addr, 32'h200);
        check("br_rfe_isr", {31'd0, ISR}, 32'd1);

        // flush with ready: word dropped, PC advances
        step();
        check("pre_flush_ir", IFID_IR, 32'hC000_0200);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush_ir", IFID_IR, 32'h0);
        check("flush_addr", imem_addr, 32'h208);
        check("flush_pcout", PC_out, 32'h204);

        // asynchronous reset mid-WAIT
        imem_ready = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_isr", {31'd0, ISR}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
